// File: rtl/chu_io_pwm_capture_core.sv
// chu_io_pwm_capture_core: per-channel PWM period / high-time capture behind a 32-bit slot bus.
// Optional PWM_CAP_TIMEOUT_EN: a measurement whose period counter saturates is abandoned.
module chu_io_pwm_capture_core #(
    parameter int W = 4,
    parameter int C = 24
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    input  logic [W-1:0] pwm_in
);
    typedef enum logic {IDLE, MEASURE} state_t;

    localparam logic [C-1:0] CNT_MAX = '1;
    localparam logic [C-1:0] CNT_ONE = C'(1);

    logic [W-1:0] enable;
    logic         clr_hit;
    logic [W-1:0] clr_mask;
    logic [7:0]   valid_bits;
    logic [7:0]   overflow_bits;
    logic [7:0]   timeout_bits;
    logic [C-1:0] high_regs   [8];
    logic [C-1:0] period_regs [8];
    logic         unused_bits;

    assign clr_hit     = cs && write && (addr == 5'h02);
    assign clr_mask    = wr_data[W-1:0];
    assign unused_bits = &{1'b0, read, wr_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            enable <= '0;
        else if (cs && write && (addr == 5'h01))
            enable <= wr_data[W-1:0];
    end

    // Slots 0..7 always exist so the read mux indexes with addr[2:0] directly.
    for (genvar i = 0; i < 8; i++) begin : g_slot
        if (i < W) begin : g_ch
            logic         sync_a, sync_b, prev;
            logic         rising;
            state_t       state, state_next;
            logic [C-1:0] period_cnt, period_next, period_inc;
            logic [C-1:0] high_cnt, high_next, high_inc;
            logic [C-1:0] period_reg, high_reg;
            logic         capture, sat_hit;
            logic         valid, overflow;
`ifdef PWM_CAP_TIMEOUT_EN
            logic         timeout, timeout_hit;
`endif

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync_a <= 1'b0;
                    sync_b <= 1'b0;
                    prev   <= 1'b0;
                end else begin
                    sync_a <= pwm_in[i];
                    sync_b <= sync_a;
                    prev   <= sync_b;
                end
            end

            assign rising     = sync_b & ~prev;
            assign period_inc = (period_cnt == CNT_MAX) ? CNT_MAX : period_cnt + CNT_ONE;
            assign high_inc   = (high_cnt == CNT_MAX) ? CNT_MAX : high_cnt + CNT_ONE;

            // The edge cycle itself starts the new interval, hence the reload value of 1.
            always_comb begin
                state_next  = state;
                period_next = period_cnt;
                high_next   = high_cnt;
                capture     = 1'b0;
                sat_hit     = 1'b0;
`ifdef PWM_CAP_TIMEOUT_EN
                timeout_hit = 1'b0;
`endif
                if (!enable[i]) begin
                    state_next  = IDLE;
                    period_next = '0;
                    high_next   = '0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (rising) begin
                                state_next  = MEASURE;
                                period_next = CNT_ONE;
                                high_next   = CNT_ONE;
                            end
                        end
                        MEASURE: begin
                            if (rising) begin
                                capture     = 1'b1;
                                period_next = CNT_ONE;
                                high_next   = CNT_ONE;
                            end else begin
                                period_next = period_inc;
                                if (sync_b)
                                    high_next = high_inc;
                                sat_hit = (period_inc == CNT_MAX) || (sync_b && (high_inc == CNT_MAX));
`ifdef PWM_CAP_TIMEOUT_EN
                                if (period_inc == CNT_MAX) begin
                                    timeout_hit = 1'b1;
                                    state_next  = IDLE;
                                    period_next = '0;
                                    high_next   = '0;
                                end
`endif
                            end
                        end
                        default: state_next = IDLE;
                    endcase
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state      <= IDLE;
                    period_cnt <= '0;
                    high_cnt   <= '0;
                    period_reg <= '0;
                    high_reg   <= '0;
                    valid      <= 1'b0;
                    overflow   <= 1'b0;
                end else begin
                    state      <= state_next;
                    period_cnt <= period_next;
                    high_cnt   <= high_next;
                    if (capture) begin
                        period_reg <= period_cnt;
                        high_reg   <= high_cnt;
                    end
                    // A capture landing on a clear write leaves the channel valid.
                    if (capture)
                        valid <= 1'b1;
                    else if (clr_hit && clr_mask[i])
                        valid <= 1'b0;
                    if (sat_hit)
                        overflow <= 1'b1;
                    else if (clr_hit && clr_mask[i])
                        overflow <= 1'b0;
                end
            end

`ifdef PWM_CAP_TIMEOUT_EN
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    timeout <= 1'b0;
                else if (timeout_hit)
                    timeout <= 1'b1;
                else if (clr_hit && clr_mask[i])
                    timeout <= 1'b0;
            end
            assign timeout_bits[i] = timeout;
`else
            assign timeout_bits[i] = 1'b0;
`endif
            assign valid_bits[i]    = valid;
            assign overflow_bits[i] = overflow;
            assign high_regs[i]     = high_reg;
            assign period_regs[i]   = period_reg;
        end else begin : g_none
            assign valid_bits[i]    = 1'b0;
            assign overflow_bits[i] = 1'b0;
            assign timeout_bits[i]  = 1'b0;
            assign high_regs[i]     = '0;
            assign period_regs[i]   = '0;
        end
    end

    always_comb begin
        rd_data = '0;
        if (addr == 5'h00)
            rd_data = {8'h00, timeout_bits, overflow_bits, valid_bits};
        else if (addr == 5'h01)
            rd_data[W-1:0] = enable;
        else if (addr[4:3] == 2'b10)
            rd_data = 32'(high_regs[addr[2:0]]);
        else if (addr[4:3] == 2'b11)
            rd_data = 32'(period_regs[addr[2:0]]);
    end

endmodule

// File: tb/tb_chu_io_pwm_capture_core.sv
// tb_chu_io_pwm_capture_core: register-map vectors, directed capture corner cases and a
// randomized four-channel run checked against an edge-interval reference model.
module tb_chu_io_pwm_capture_core;
    localparam int W = 4;
    localparam int C = 16;
    localparam int RAND_CYCLES = 3000;

    logic         clk = 1'b0;
    logic         reset;
    logic         cs;
    logic         read;
    logic         write;
    logic [4:0]   addr;
    logic [31:0]  wr_data;
    logic [31:0]  rd_data;
    logic [W-1:0] pwm_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit          is_write;
        logic [4:0]  a;
        logic [31:0] data;
        logic [31:0] expected;
        string       name;
    } vec_t;

    typedef struct {
        int vis;
        int ch;
        int per;
        int hi;
    } cap_t;

    vec_t vecs[$];
    cap_t pending[$];

    chu_io_pwm_capture_core #(.W(W), .C(C)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .pwm_in  (pwm_in)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    task automatic check_reg(input string name, input logic [4:0] a, input logic [31:0] expected);
        cs   = 1'b1;
        read = 1'b1;
        addr = a;
        #1;
        checkOutput(name, rd_data, expected);
        read = 1'b0;
        cs   = 1'b0;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = a;
        wr_data = d;
        tick();
        cs      = 1'b0;
        write   = 1'b0;
    endtask

    task automatic hold(input int ch, input logic lev, input int n);
        pwm_in[ch] = lev;
        repeat (n) tick();
    endtask

    task automatic run_wave(input int ch, input int per, input int hi, input int n);
        for (int p = 0; p < n; p++) begin
            for (int j = 0; j < per; j++) begin
                pwm_in[ch] = (j < hi);
                tick();
            end
        end
    endtask

    task automatic add_vec(input bit w, input logic [4:0] a, input logic [31:0] d,
                           input logic [31:0] e, input string name);
        vec_t v;
        v.is_write = w;
        v.a        = a;
        v.data     = d;
        v.expected = e;
        v.name     = name;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.is_write) begin
            bus_write(v.a, v.data);
        end else begin
            check_reg(v.name, v.a, v.expected);
            tick();
        end
    endtask

    task automatic random_run();
        int          per[W];
        int          hi[W];
        int          phase[W];
        int          last_edge[W];
        int          acc[W];
        int          m_per[W];
        int          m_hi[W];
        logic [W-1:0] last_lev;
        logic [W-1:0] lev;
        logic [W-1:0] m_valid;
        logic [W-1:0] pend_clear;
        logic [W-1:0] mask;
        int          sel;
        logic [4:0]  a;
        logic [31:0] expected;
        cap_t        c;

        last_lev   = '0;
        m_valid    = '0;
        pend_clear = '0;
        for (int ch = 0; ch < W; ch++) begin
            per[ch]       = int'($urandom_range(40, 2));
            hi[ch]        = int'($urandom_range(per[ch] - 1, 1));
            phase[ch]     = int'($urandom_range(per[ch], 0));
            last_edge[ch] = -1;
            acc[ch]       = 0;
            m_per[ch]     = 0;
            m_hi[ch]      = 0;
        end

        for (int n = 0; n < RAND_CYCLES; n++) begin
            for (int ch = 0; ch < W; ch++) begin
                if (phase[ch] >= per[ch]) begin
                    per[ch]   = int'($urandom_range(40, 2));
                    hi[ch]    = int'($urandom_range(per[ch] - 1, 1));
                    phase[ch] = 0;
                end
                lev[ch] = (phase[ch] < hi[ch]);
                phase[ch]++;
                // Each rising edge closes the interval opened by the previous one.
                if (lev[ch] && !last_lev[ch]) begin
                    if (last_edge[ch] >= 0) begin
                        c.vis = cyc + 3;
                        c.ch  = ch;
                        c.per = cyc - last_edge[ch];
                        c.hi  = acc[ch];
                        pending.push_back(c);
                    end
                    last_edge[ch] = cyc;
                    acc[ch]       = 0;
                end
                if (lev[ch])
                    acc[ch]++;
                last_lev[ch] = lev[ch];
            end
            pwm_in = lev;

            if ($urandom_range(29, 0) == 0) begin
                mask       = W'($urandom_range(15, 0));
                cs         = 1'b1;
                write      = 1'b1;
                addr       = 5'h02;
                wr_data    = 32'(mask);
                pend_clear = mask;
            end else begin
                sel = int'($urandom_range(8, 0));
                if (sel == 0) begin
                    a        = 5'h00;
                    expected = 32'(m_valid);
                end else if (sel <= 4) begin
                    a        = 5'(16 + sel - 1);
                    expected = 32'(m_hi[sel - 1]);
                end else begin
                    a        = 5'(24 + sel - 5);
                    expected = 32'(m_per[sel - 5]);
                end
                check_reg($sformatf("rand_a%02h_c%0d", a, cyc), a, expected);
            end

            tick();
            cs         = 1'b0;
            write      = 1'b0;
            m_valid    = m_valid & ~pend_clear;
            pend_clear = '0;
            while (pending.size() > 0 && pending[0].vis <= cyc) begin
                m_per[pending[0].ch]   = pending[0].per;
                m_hi[pending[0].ch]    = pending[0].hi;
                m_valid[pending[0].ch] = 1'b1;
                void'(pending.pop_front());
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        cs      = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        wr_data = '0;
        pwm_in  = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        add_vec(0, 5'h00, 32'h0,        32'h0, "rst_status");
        add_vec(0, 5'h01, 32'h0,        32'h0, "rst_enable");
        add_vec(0, 5'h10, 32'h0,        32'h0, "rst_high0");
        add_vec(0, 5'h13, 32'h0,        32'h0, "rst_high3");
        add_vec(0, 5'h18, 32'h0,        32'h0, "rst_period0");
        add_vec(0, 5'h1B, 32'h0,        32'h0, "rst_period3");
        add_vec(1, 5'h01, 32'hFFFFFFF5, 32'h0, "");
        add_vec(0, 5'h01, 32'h0,        32'h5, "enable_mask_width");
        add_vec(1, 5'h05, 32'hFFFFFFFF, 32'h0, "");
        add_vec(0, 5'h05, 32'h0,        32'h0, "unmapped_read");
        add_vec(0, 5'h01, 32'h0,        32'h5, "enable_after_unmapped_wr");
        add_vec(1, 5'h00, 32'hFFFFFFFF, 32'h0, "");
        add_vec(0, 5'h00, 32'h0,        32'h0, "status_not_writable");
        add_vec(1, 5'h10, 32'hFFFFFFFF, 32'h0, "");
        add_vec(0, 5'h10, 32'h0,        32'h0, "high_not_writable");
        add_vec(0, 5'h14, 32'h0,        32'h0, "high_ch4_absent");
        add_vec(0, 5'h1F, 32'h0,        32'h0, "period_ch7_absent");
        add_vec(0, 5'h0F, 32'h0,        32'h0, "unmapped_0f");
        add_vec(1, 5'h01, 32'h0,        32'h0, "");
        add_vec(0, 5'h01, 32'h0,        32'h0, "enable_cleared");
        foreach (vecs[k]) applyStimulus(vecs[k]);

        // 100 / 25 square wave; capture must appear exactly 3 cycles after the edge.
        bus_write(5'h01, 32'h1);
        hold(0, 1'b0, 5);
        run_wave(0, 100, 25, 1);
        pwm_in[0] = 1'b1;
        tick();
        tick();
        check_reg("latency_not_yet", 5'h00, 32'h0);
        tick();
        check_reg("sq_period", 5'h18, 32'd100);
        check_reg("sq_high", 5'h10, 32'd25);
        check_reg("sq_status", 5'h00, 32'h1);

        // Clear write on the capture cycle, then a plain clear.
        hold(0, 1'b1, 22);
        hold(0, 1'b0, 35);
        pwm_in[0] = 1'b1;
        tick();
        tick();
        bus_write(5'h02, 32'h1);
        check_reg("clr_race_status", 5'h00, 32'h1);
        check_reg("clr_race_period", 5'h18, 32'd60);
        check_reg("clr_race_high", 5'h10, 32'd25);
        bus_write(5'h02, 32'h1);
        check_reg("clr_status", 5'h00, 32'h0);

        // Disable mid-period, re-enable, first capture must be clean.
        hold(0, 1'b1, 10);
        hold(0, 1'b0, 20);
        bus_write(5'h01, 32'h0);
        check_reg("dis_status", 5'h00, 32'h0);
        check_reg("dis_period_held", 5'h18, 32'd60);
        check_reg("dis_high_held", 5'h10, 32'd25);
        hold(0, 1'b0, 30);
        bus_write(5'h01, 32'h1);
        hold(0, 1'b0, 5);
        pwm_in[0] = 1'b1;
        tick();
        tick();
        tick();
        check_reg("reen_first_edge", 5'h00, 32'h0);
        hold(0, 1'b1, 9);
        hold(0, 1'b0, 33);
        pwm_in[0] = 1'b1;
        tick();
        tick();
        tick();
        check_reg("reen_period", 5'h18, 32'd45);
        check_reg("reen_high", 5'h10, 32'd12);
        check_reg("reen_status", 5'h00, 32'h1);

        // Constant-level inputs on channel 1.
        bus_write(5'h01, 32'h3);
        pwm_in[0] = 1'b0;
        hold(1, 1'b0, 200);
        check_reg("duty0_status", 5'h00, 32'h1);
        check_reg("duty0_high", 5'h11, 32'h0);
        check_reg("duty0_period", 5'h19, 32'h0);
        hold(1, 1'b1, 300);
        check_reg("duty100_status", 5'h00, 32'h1);
        check_reg("duty100_high", 5'h11, 32'h0);
        check_reg("duty100_period", 5'h19, 32'h0);

        // 70000-cycle period saturates the 16-bit counter.
        bus_write(5'h01, 32'h0);
        bus_write(5'h01, 32'h1);
        bus_write(5'h02, 32'hF);
        check_reg("long_pre_status", 5'h00, 32'h0);
        hold(0, 1'b0, 5);
        hold(0, 1'b1, 100);
        hold(0, 1'b0, 69900);
        pwm_in[0] = 1'b1;
        tick();
        tick();
        tick();
`ifdef PWM_CAP_TIMEOUT_EN
        check_reg("long_status", 5'h00, 32'h0001_0100);
        check_reg("long_period", 5'h18, 32'd45);
        check_reg("long_high", 5'h10, 32'd12);
`else
        check_reg("long_status", 5'h00, 32'h0000_0101);
        check_reg("long_period", 5'h18, 32'd65535);
        check_reg("long_high", 5'h10, 32'd100);
`endif
        bus_write(5'h02, 32'h1);
        check_reg("long_clr_status", 5'h00, 32'h0);

        // Reset in the middle of a measurement.
        hold(0, 1'b1, 5);
        reset = 1'b1;
        check_reg("inrst_status", 5'h00, 32'h0);
        check_reg("inrst_enable", 5'h01, 32'h0);
        check_reg("inrst_high0", 5'h10, 32'h0);
        tick();
        check_reg("inrst_period0", 5'h18, 32'h0);
        check_reg("inrst_period1", 5'h19, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        check_reg("postrst_period0", 5'h18, 32'h0);
        check_reg("postrst_high0", 5'h10, 32'h0);
        check_reg("postrst_status", 5'h00, 32'h0);
        hold(0, 1'b0, 5);
        bus_write(5'h01, 32'h1);
        hold(0, 1'b0, 3);
        pwm_in[0] = 1'b1;
        tick();
        tick();
        tick();
        check_reg("postrst_first_edge", 5'h00, 32'h0);
        hold(0, 1'b1, 7);
        hold(0, 1'b0, 40);
        run_wave(0, 50, 10, 1);
        pwm_in[0] = 1'b1;
        tick();
        tick();
        tick();
        check_reg("postrst_period", 5'h18, 32'd50);
        check_reg("postrst_high", 5'h10, 32'd10);
        check_reg("postrst_valid", 5'h00, 32'h1);

        // Randomized waves on all channels from a clean reset.
        pwm_in = '0;
        reset  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        bus_write(5'h01, 32'hF);
        repeat (3) tick();
        random_run();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chu_io_pwm_capture_core.md
CHU_IO_PWM_CAPTURE_CORE -- requirements
Module: chu_io_pwm_capture_core

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the number of PWM input channels (legal range 1..8).
REQ-002 The block SHALL have parameter C, default 24, giving the width of the period and high-time counters (legal range 8..32).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, an asynchronous, active-high reset.
REQ-005 The block SHALL have port cs, input, 1 bit, slot chip select.
REQ-006 The block SHALL have port read, input, 1 bit, slot read strobe (informational; reads are side-effect free).
REQ-007 The block SHALL have port write, input, 1 bit, slot write strobe.
REQ-008 The block SHALL have port addr, input, 5 bits, slot register address.
REQ-009 The block SHALL have port wr_data, input, 32 bits, slot write data.
REQ-010 The block SHALL have port rd_data, output, 32 bits, slot read data, combinationally decoded from addr.
REQ-011 The block SHALL have port pwm_in, input, W bits, asynchronous external PWM signals to be measured.

Function
REQ-012 Register map: addr 0 is status (read), addr 1 is enable mask (read/write, bits W-1:0), and a write to addr 2 clears valid bits selected by wr_data[W-1:0].
REQ-013 Register map: addr 0x10+i reads the high-time of channel i, and addr 0x18+i reads the period of channel i; both are zero-extended to 32 bits.
REQ-014 Status: bits 7:0 are valid[i], bits 15:8 are overflow[i], and bits 23:16 are timeout[i]; bits for unimplemented channels read 0.
REQ-015 Unmapped addresses SHALL read 0, and writes to them SHALL have no effect.
REQ-016 Each pwm_in bit SHALL pass through a 2-flop synchronizer followed by a registered previous-value flop; a rising edge is sync=1 and prev=0.
REQ-017 Each channel SHALL implement an FSM with states IDLE and MEASURE.
REQ-018 In IDLE, a rising edge with enable[i]=1 SHALL move the channel to MEASURE and load period_cnt=1 and high_cnt=1.
REQ-019 In MEASURE, each cycle SHALL increment period_cnt, and SHALL increment high_cnt when sync=1.
REQ-020 Counters SHALL saturate at 2^C-1; on reaching saturation, overflow[i] is set.
REQ-021 On a rising edge in MEASURE: period_reg <= period_cnt, high_reg <= high_cnt, valid[i] <= 1, and the counters reload to 1.
REQ-022 The captured period SHALL equal the exact count of clk cycles between consecutive synchronized rising edges, and the captured high time SHALL equal the count of sync-high cycles in that interval.
REQ-023 Capture latency SHALL be 3 clk cycles from a pin edge meeting setup to updated registers visible on rd_data.
REQ-024 When enable[i] is cleared, the channel SHALL return to IDLE and clear its counters; latched registers and status bits SHALL hold.
REQ-025 When a clear write and a capture occur in the same cycle on a channel, the capture SHALL win and valid[i]=1.
REQ-026 A clear write SHALL also clear overflow[i] and timeout[i] for the selected channels.
REQ-027 A constant-level input SHALL never produce a capture.

Reset
REQ-028 Reset SHALL clear synchronizers, prev flops, counters, period_reg, high_reg, enable, valid, overflow and timeout to 0, and place all FSMs in IDLE.
REQ-029 While reset is asserted, rd_data SHALL reflect the cleared registers (0 for all mapped addresses).
REQ-030 Reset asserted mid-measurement SHALL discard the partial measurement.

Configuration
REQ-031 With PWM_CAP_TIMEOUT_EN defined, period_cnt reaching 2^C-1 in MEASURE SHALL set timeout[i] and return the channel to IDLE without updating latched registers.
REQ-032 With PWM_CAP_TIMEOUT_EN undefined, the channel SHALL remain in MEASURE with the counters saturated, timeout bits SHALL read 0, and no timeout logic SHALL be synthesized.

Verification (C=16, W=4)
REQ-033 Bench SHALL drive enable=0x1 and a 100-cycle period / 25-high square wave on pwm_in[0] -> after the second edge plus 3 cycles, addr 0x18 reads 100, addr 0x10 reads 25, and status bit 0 is 1.
REQ-034 Bench SHALL drive a 0% duty (constant 0) and a 100% duty (constant 1) input on channel 1 -> valid[1] stays 0 and the latched registers stay 0.
REQ-035 Bench SHALL write addr 2 = 0x1 in the same cycle as a channel 0 capture -> valid[0] reads 1 and the new period is latched.
REQ-036 Bench SHALL apply a 70000-cycle period -> overflow[0]=1 and period reads 65535; with PWM_CAP_TIMEOUT_EN, timeout[0]=1 and the latched registers are unchanged.
REQ-037 Bench SHALL clear enable[0] mid-period, re-enable it, then apply edges -> the first capture after re-enable reports the full correct period with no carry-over.
REQ-038 Bench SHALL assert reset mid-measurement and then drive a 50-cycle / 10-high wave -> all registers read 0 after reset, and subsequent captures read 50 / 10.
